rs_issue_select: RTL and testbench
==================================

Name: rs_issue_select

Overview:
- Issue stage directly downstream of the per-entry reservation stations (one instance per RS bank / FU class).
- Each cycle it picks one ready RS entry by round-robin priority, and asserts that entry's use-enable and free.
- It captures the entry's operands and tags into an output pipeline register feeding the functional unit, with a valid/ready handshake for FU back-pressure.

Parameters:
- NUM_RS, 8, number of RS entries arbitrated (2..16; need not be a power of 2)
- PRN_W, `PRN_BITS, physical-register tag width
- ROB_W, `ROB_BITS, ROB index width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  mispredict squash; kills output register and suppresses issue this cycle
- rs_ready_in  in  NUM_RS  per-entry ready (in use and both operands valid)
- rs_opa_in  in  64  wired-OR operand A bus; only the use-enabled entry drives non-zero
- rs_opb_in  in  64  wired-OR operand B bus
- rs_func_in  in  NUM_RS*5  flattened per-entry FunctionCode; entry i at [5i+4:5i]
- rs_prn_in  in  NUM_RS*PRN_W  flattened per-entry PRNum
- rs_rob_in  in  NUM_RS*ROB_W  flattened per-entry ROBNum
- rs_use_enable_out  out  NUM_RS  one-hot operand-drive select to RS entries, combinational
- rs_free_out  out  NUM_RS  one-hot free to RS entries, combinational, equal to rs_use_enable_out
- fu_ready_in  in  1  FU accepts the output register this cycle
- fu_valid_out  out  1  output register holds an instruction
- fu_opa_out  out  64  registered operand A
- fu_opb_out  out  64  registered operand B
- fu_func_out  out  5  registered FunctionCode
- fu_prn_out  out  PRN_W  registered destination PR
- fu_rob_out  out  ROB_W  registered ROB index

Behaviour:
- Reset (reset==0, asynchronous):
  - fu_valid_out=0; fu_opa/opb/func/prn/rob_out=0; rr_ptr=0.
  - Combinational outputs are 0 while reset is asserted.
- can_accept = ~fu_valid_out | fu_ready_in.
- any_ready = |rs_ready_in.
- issue_fire = any_ready & can_accept & ~flush.
- Selection (combinational):
  - sel = first i with rs_ready_in[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_RS.
  - rs_use_enable_out = rs_free_out = issue_fire ? onehot(sel) : 0. Never more than one bit set.
- Capture, same cycle:
  - fu_opa/opb come from rs_opa_in/rs_opb_in, which the selected entry drives because of use_enable.
  - func/prn/rob are muxed from the flattened arrays at index sel.
- On the edge with issue_fire:
  - Output register loads the captured values; fu_valid_out<=1.
  - rr_ptr <= (sel==NUM_RS-1) ? 0 : sel+1.
  - The RS entry clears InUse on the same edge, so it is not ready next cycle.
- On the edge with no issue_fire:
  - If fu_ready_in & fu_valid_out: fu_valid_out<=0.
  - Otherwise hold all registers and rr_ptr.
- Latency: selection to fu_valid_out is 1 cycle. Back-to-back issue is sustained at 1/cycle while fu_ready_in=1.
- Stall (fu_valid_out=1, fu_ready_in=0):
  - No use_enable, no free.
  - Output register and rr_ptr hold unchanged.
- Flush:
  - fu_valid_out<=0 next edge, overriding any pending handoff.
  - No use_enable/free that cycle; rr_ptr holds.
  - Output data registers need not be cleared.
- Simultaneous handoff and issue (fu_valid_out=1, fu_ready_in=1, ready entry present): new instruction replaces the old one; fu_valid_out stays 1.
- No ready entries: outputs idle; an existing valid is drained normally.
- Data registers update only on issue_fire (no load on idle cycles).

Decomposition:
- Shared defines header supplies `PRN_BITS, `ROB_BITS and the 5-bit FunctionCode encoding. No new package types.
- One natural sub-module: rr_arbiter (NUM_RS-wide request vector plus pointer -> one-hot grant and binary index).
- The output register stays in the top level.

Test Plan:
- Reset release, rs_ready_in=0 -> fu_valid_out=0, use_enable=0 for many cycles; reset asserted mid-stream drops fu_valid_out immediately, without waiting for a clock edge.
- rs_ready_in=8'b0010_0100, rr_ptr=0, fu_ready_in=1:
  - Cycle 0: use_enable=8'b0000_0100.
  - Next cycle, with entry 2 now freed: use_enable=8'b0010_0000.
  - FU sees entry 2 then entry 5 data on consecutive cycles.
- All 8 entries ready continuously, fu_ready_in=1 -> grant order 0,1,...,7,0; rr_ptr wraps to 0 after entry 7; no entry starved.
- Stall: fu_valid_out=1 holding opa=64'h1234, fu_ready_in=0 for 3 cycles with entry 3 ready:
  - use_enable=0 and output holds 64'h1234 throughout.
  - On the cycle fu_ready_in=1, entry 3 is enabled and loaded next edge.
- flush=1 while entry 1 is ready and fu_valid_out=1 -> use_enable=0, fu_valid_out=0 next cycle, rr_ptr unchanged.
- NUM_RS=6 instance, only entry 5 ready, rr_ptr=5 -> grant 5, rr_ptr becomes 0 (non-power-of-2 wrap).

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// Shared definitions for the reservation-station issue select block:
// default tag widths and the 5-bit FunctionCode encoding.
`ifndef PRN_BITS
`define PRN_BITS 6
`endif
`ifndef ROB_BITS
`define ROB_BITS 5
`endif

package rs_issue_select_pkg;

    // Width of the FunctionCode carried by each RS entry.
    localparam int FUNC_W = 5;

    // FunctionCode encoding shared with the RS entries and functional units.
    localparam logic [FUNC_W-1:0] FUNC_NOP = 5'd0;
    localparam logic [FUNC_W-1:0] FUNC_ADD = 5'd1;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 5'd2;
    localparam logic [FUNC_W-1:0] FUNC_AND = 5'd3;
    localparam logic [FUNC_W-1:0] FUNC_OR  = 5'd4;
    localparam logic [FUNC_W-1:0] FUNC_XOR = 5'd5;
    localparam logic [FUNC_W-1:0] FUNC_SLL = 5'd6;
    localparam logic [FUNC_W-1:0] FUNC_SRL = 5'd7;
    localparam logic [FUNC_W-1:0] FUNC_SRA = 5'd8;
    localparam logic [FUNC_W-1:0] FUNC_SLT = 5'd9;
    localparam logic [FUNC_W-1:0] FUNC_MUL = 5'd10;

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr, wrapping
// modulo NUM_RS (which need not be a power of two), and returns the first
// requester as a one-hot grant plus its binary index.
`default_nettype none

module rs_issue_select_rr_arbiter
    import rs_issue_select_pkg::*;
#(
    parameter int NUM_RS = 8,
    parameter int PTR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_RS-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              any_req
);

    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] cand_idx;
    logic             found;

    assign any_req = |req;

    // Walk ptr, ptr+1, ... with explicit wrap; first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        cand_idx  = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_RS)) begin
                cand = cand - (PTR_W + 1)'(NUM_RS);
            end
            cand_idx = cand[PTR_W-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_issue_select.sv
// Issue select: picks one ready RS entry per cycle by round-robin priority,
// enables/frees it, and captures its operands and tags into the output
// register feeding the functional unit.
//
// FU handshake: fu_valid_out/fu_ready_in follow strict valid/ready rules --
// a transfer happens on a rising edge where both are 1; while fu_valid_out is
// 1 and fu_ready_in is 0 the output register holds all its fields unchanged.
// A new instruction may be loaded on the same edge that hands the old one off.
`default_nettype none

module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int NUM_RS = 8,
    parameter int PRN_W  = `PRN_BITS,
    parameter int ROB_W  = `ROB_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_RS-1:0]        rs_ready_in,
    input  logic [63:0]              rs_opa_in,
    input  logic [63:0]              rs_opb_in,
    input  logic [NUM_RS*FUNC_W-1:0] rs_func_in,
    input  logic [NUM_RS*PRN_W-1:0]  rs_prn_in,
    input  logic [NUM_RS*ROB_W-1:0]  rs_rob_in,
    output logic [NUM_RS-1:0]        rs_use_enable_out,
    output logic [NUM_RS-1:0]        rs_free_out,
    input  logic                     fu_ready_in,
    output logic                     fu_valid_out,
    output logic [63:0]              fu_opa_out,
    output logic [63:0]              fu_opb_out,
    output logic [FUNC_W-1:0]        fu_func_out,
    output logic [PRN_W-1:0]         fu_prn_out,
    output logic [ROB_W-1:0]         fu_rob_out
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_ptr_next;
    logic [PTR_W-1:0]  sel_idx;
    logic [NUM_RS-1:0] sel_grant;
    logic              any_ready;
    logic              can_accept;
    logic              issue_fire;
    logic [FUNC_W-1:0] sel_func;
    logic [PRN_W-1:0]  sel_prn;
    logic [ROB_W-1:0]  sel_rob;

    rs_issue_select_rr_arbiter #(
        .NUM_RS (NUM_RS),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req       (rs_ready_in),
        .ptr       (rr_ptr),
        .grant     (sel_grant),
        .grant_idx (sel_idx),
        .any_req   (any_ready)
    );

    // The output slot is free if empty or being handed off this cycle.
    assign can_accept = ~fu_valid_out | fu_ready_in;

    // Gating with reset keeps the RS-facing strobes low while reset is held.
    assign issue_fire = any_ready & can_accept & ~flush & reset;

    assign rs_use_enable_out = issue_fire ? sel_grant : '0;
    assign rs_free_out       = issue_fire ? sel_grant : '0;

    // Tags come from the flattened per-entry arrays; operands arrive on the
    // wired-OR buses driven by the use-enabled entry.
    assign sel_func = rs_func_in[int'(sel_idx) * FUNC_W +: FUNC_W];
    assign sel_prn  = rs_prn_in[int'(sel_idx) * PRN_W +: PRN_W];
    assign sel_rob  = rs_rob_in[int'(sel_idx) * ROB_W +: ROB_W];

    // Pointer moves just past the winner, wrapping at NUM_RS-1.
    assign rr_ptr_next = (sel_idx == PTR_W'(NUM_RS - 1)) ? '0 : sel_idx + 1'b1;

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fu_valid_out <= 1'b0;
            fu_opa_out   <= '0;
            fu_opb_out   <= '0;
            fu_func_out  <= '0;
            fu_prn_out   <= '0;
            fu_rob_out   <= '0;
            rr_ptr       <= '0;
        end else if (issue_fire) begin
            fu_valid_out <= 1'b1;
            fu_opa_out   <= rs_opa_in;
            fu_opb_out   <= rs_opb_in;
            fu_func_out  <= sel_func;
            fu_prn_out   <= sel_prn;
            fu_rob_out   <= sel_rob;
            rr_ptr       <= rr_ptr_next;
        end else if (flush) begin
            fu_valid_out <= 1'b0;
        end else if (fu_ready_in && fu_valid_out) begin
            fu_valid_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: an 8-entry and a 6-entry instance,
// with a small RS model driving the wired-OR operand buses.
`default_nettype none

module tb_rs_issue_select;

    // Clock and reset
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared controls
    logic flush;
    logic fu_ready;

    // 8-entry instance signals
    logic [7:0]  ready8;
    logic [63:0] opa8, opb8;
    logic [39:0] func8;
    logic [47:0] prn8;
    logic [39:0] rob8;
    logic [7:0]  use_en8, free8;
    logic        valid8;
    logic [63:0] fu_opa8, fu_opb8;
    logic [4:0]  fu_func8;
    logic [5:0]  fu_prn8;
    logic [4:0]  fu_rob8;
    logic [63:0] opa_val8 [8];
    logic [63:0] opb_val8 [8];

    // 6-entry instance signals
    logic [5:0]  ready6;
    logic [63:0] opa6, opb6;
    logic [29:0] func6;
    logic [35:0] prn6;
    logic [29:0] rob6;
    logic [5:0]  use_en6, free6;
    logic        valid6;
    logic [63:0] fu_opa6, fu_opb6;
    logic [4:0]  fu_func6;
    logic [5:0]  fu_prn6;
    logic [4:0]  fu_rob6;

    int tests_run;
    int tests_failed;

    rs_issue_select #(.NUM_RS(8), .PRN_W(6), .ROB_W(5)) u_dut8 (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .rs_ready_in       (ready8),
        .rs_opa_in         (opa8),
        .rs_opb_in         (opb8),
        .rs_func_in        (func8),
        .rs_prn_in         (prn8),
        .rs_rob_in         (rob8),
        .rs_use_enable_out (use_en8),
        .rs_free_out       (free8),
        .fu_ready_in       (fu_ready),
        .fu_valid_out      (valid8),
        .fu_opa_out        (fu_opa8),
        .fu_opb_out        (fu_opb8),
        .fu_func_out       (fu_func8),
        .fu_prn_out        (fu_prn8),
        .fu_rob_out        (fu_rob8)
    );

    rs_issue_select #(.NUM_RS(6), .PRN_W(6), .ROB_W(5)) u_dut6 (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .rs_ready_in       (ready6),
        .rs_opa_in         (opa6),
        .rs_opb_in         (opb6),
        .rs_func_in        (func6),
        .rs_prn_in         (prn6),
        .rs_rob_in         (rob6),
        .rs_use_enable_out (use_en6),
        .rs_free_out       (free6),
        .fu_ready_in       (fu_ready),
        .fu_valid_out      (valid6),
        .fu_opa_out        (fu_opa6),
        .fu_opb_out        (fu_opb6),
        .fu_func_out       (fu_func6),
        .fu_prn_out        (fu_prn6),
        .fu_rob_out        (fu_rob6)
    );

    // RS model: only use-enabled entries drive the wired-OR operand buses.
    always_comb begin
        opa8 = '0;
        opb8 = '0;
        for (int i = 0; i < 8; i++) begin
            if (use_en8[i]) begin
                opa8 = opa8 | opa_val8[i];
                opb8 = opb8 | opb_val8[i];
            end
        end
    end

    always_comb begin
        opa6 = '0;
        opb6 = '0;
        for (int i = 0; i < 6; i++) begin
            if (use_en6[i]) begin
                opa6 = opa6 | (64'h2000 + 64'(i));
                opb6 = opb6 | (64'h3000 + 64'(i));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] exp_g;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Entry i: opa 0x1000+i, opb 0x5000+i, func i+1, prn i+8, rob i+16.
        for (int i = 0; i < 8; i++) begin
            opa_val8[i]        = 64'h1000 + 64'(i);
            opb_val8[i]        = 64'h5000 + 64'(i);
            func8[i*5 +: 5]    = 5'(i + 1);
            prn8[i*6 +: 6]     = 6'(i + 8);
            rob8[i*5 +: 5]     = 5'(i + 16);
        end
        for (int i = 0; i < 6; i++) begin
            func6[i*5 +: 5]    = 5'(i + 1);
            prn6[i*6 +: 6]     = 6'(i + 8);
            rob6[i*5 +: 5]     = 5'(i + 16);
        end

        // Reset held with every entry ready: strobes must stay low.
        reset    = 1'b0;
        flush    = 1'b0;
        fu_ready = 1'b1;
        ready8   = 8'hFF;
        ready6   = 6'h3F;
        #2;
        check("rst_valid8", 64'(valid8), 64'd0);
        check("rst_opa8", fu_opa8, 64'd0);
        check("rst_use_en8", 64'(use_en8), 64'd0);
        check("rst_use_en6", 64'(use_en6), 64'd0);
        #10;
        reset  = 1'b1;
        ready8 = 8'h00;
        ready6 = 6'h00;

        // Idle after reset release.
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_valid8", 64'(valid8), 64'd0);
            check("idle_use_en8", 64'(use_en8), 64'd0);
        end

        // Entries 2 and 5 ready, pointer at 0.
        ready8 = 8'b0010_0100;
        #1;
        check("rr_use_en_e2", 64'(use_en8), 64'h04);
        check("rr_free_e2", 64'(free8), 64'h04);
        tick();
        check("rr_valid_e2", 64'(valid8), 64'd1);
        check("rr_opa_e2", fu_opa8, 64'h1002);
        check("rr_opb_e2", fu_opb8, 64'h5002);
        check("rr_func_e2", 64'(fu_func8), 64'd3);
        check("rr_prn_e2", 64'(fu_prn8), 64'd10);
        check("rr_rob_e2", 64'(fu_rob8), 64'd18);
        ready8 = 8'b0010_0000;
        #1;
        check("rr_use_en_e5", 64'(use_en8), 64'h20);
        tick();
        check("rr_valid_e5", 64'(valid8), 64'd1);
        check("rr_opa_e5", fu_opa8, 64'h1005);
        check("rr_func_e5", 64'(fu_func8), 64'd6);
        ready8 = 8'h00;
        tick();
        check("drain_valid", 64'(valid8), 64'd0);

        // Grant entry 7 so the pointer wraps to 0, then all entries ready.
        ready8 = 8'h80;
        #1;
        check("wrap_use_en_e7", 64'(use_en8), 64'h80);
        tick();
        ready8 = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'(1 << (k % 8));
            #1;
            check("all_use_en", 64'(use_en8), 64'(exp_g));
            tick();
            check("all_opa", fu_opa8, 64'h1000 + 64'(k % 8));
            check("all_valid", 64'(valid8), 64'd1);
        end

        // Stall: hold a 0x1234 instruction while entry 3 waits.
        ready8 = 8'h00;
        tick();
        check("stall_pre_valid", 64'(valid8), 64'd0);
        opa_val8[4] = 64'h1234;
        ready8      = 8'h10;
        fu_ready    = 1'b0;
        #1;
        check("stall_load_use_en", 64'(use_en8), 64'h10);
        tick();
        check("stall_load_opa", fu_opa8, 64'h1234);
        ready8 = 8'h08;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_use_en", 64'(use_en8), 64'd0);
            check("stall_free", 64'(free8), 64'd0);
            tick();
            check("stall_valid", 64'(valid8), 64'd1);
            check("stall_opa", fu_opa8, 64'h1234);
        end
        fu_ready = 1'b1;
        #1;
        check("unstall_use_en", 64'(use_en8), 64'h08);
        tick();
        check("unstall_opa", fu_opa8, 64'h1003);
        check("unstall_valid", 64'(valid8), 64'd1);
        opa_val8[4] = 64'h1004;

        // Flush with entry 1 ready and a valid output; pointer sits at 4.
        ready8 = 8'h02;
        flush  = 1'b1;
        #1;
        check("flush_use_en", 64'(use_en8), 64'd0);
        tick();
        check("flush_valid", 64'(valid8), 64'd0);
        flush  = 1'b0;
        // Pointer still 4: scan 4..7,0,1 picks 1 ahead of 3.
        ready8 = 8'h0A;
        #1;
        check("flush_ptr_hold", 64'(use_en8), 64'h02);
        tick();
        check("post_flush_opa", fu_opa8, 64'h1001);
        check("post_flush_valid", 64'(valid8), 64'd1);

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(valid8), 64'd0);
        check("async_rst_opa", fu_opa8, 64'd0);
        check("async_rst_use_en", 64'(use_en8), 64'd0);
        ready8 = 8'h00;
        #3;
        reset = 1'b1;
        tick();

        // Six-entry instance: grant 4, then 5 with wrap to pointer 0.
        ready6 = 6'h10;
        #1;
        check("n6_use_en_e4", 64'(use_en6), 64'h10);
        tick();
        check("n6_opa_e4", fu_opa6, 64'h2004);
        ready6 = 6'h20;
        #1;
        check("n6_use_en_e5", 64'(use_en6), 64'h20);
        tick();
        check("n6_opa_e5", fu_opa6, 64'h2005);
        check("n6_prn_e5", 64'(fu_prn6), 64'd13);
        check("n6_rob_e5", 64'(fu_rob6), 64'd21);
        ready6 = 6'h21;
        #1;
        check("n6_wrap_use_en", 64'(use_en6), 64'h01);
        tick();
        check("n6_wrap_opa", fu_opa6, 64'h2000);
        ready6 = 6'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        tests_failed++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
